sdram_avalon_arbiter: RTL
=========================

// Module: sdram_avalon_arbiter
// PURPOSE
//  Two-master Avalon-MM arbiter in front of the single Qsys SDRAM controller port.
//  Master A is the VirtualJTAG MM writer; master B is the read streamer that fills the sample RAM.
//  Replaces the static SW-driven mux with round-robin arbitration, bounded burst hold and
//  per-read owner tagging, so read data is routed to the master that issued the read.
// PARAMETERS
//  AW        25  Avalon word-address width
//  DW        16  data width; byte-enable width = DW/8
//  HOLD_MAX  16  max transfers accepted for one master before the grant must pass (>=1)
//  PEND_MAX  8   max outstanding reads; owner-tag FIFO depth, power of 2
//  B_PRIO    0   1 = B wins simultaneous requests from IDLE; 0 = round-robin
// PORTS
//  M100CLK   in   1       system clock; all logic rising-edge
//  lock      in   1       reset: synchronous, active-low (PLL lock)
//  a_read/a_write in 1    master A commands, active-high; never both asserted
//  a_addr    in   AW      master A address;  a_be in DW/8;  a_wdata in DW
//  a_waitreq out  1       stall to A: high unless A granted and slave ready
//  a_rdata   out  DW      read data to A;  a_rdvalid out 1  qualifies a_rdata
//  b_*       (as a_*)     master B, identical port set
//  s_read/s_write out 1   to SDRAM controller, active-high (inversion at Qsys top)
//  s_addr    out  AW;  s_be out DW/8;  s_wdata out DW
//  s_waitreq in   1       controller stall;  s_rdata in DW;  s_rdvalid in 1
//  gnt       out  2       {B,A} one-hot current owner, 00 in IDLE
//  pend_cnt  out  log2(PEND_MAX)+1  reads outstanding
// BEHAVIOUR
//  Reset (lock=0 at edge): state IDLE, gnt=00, hold_cnt=0, tag FIFO empty, pend_cnt=0,
//   last_owner=B (so A wins the first round-robin tie). a_/b_waitreq=1, rdvalids=0.
//  States: IDLE, OWN_A, OWN_B.
//   IDLE: A req only -> OWN_A; B only -> OWN_B; both -> B if B_PRIO else != last_owner.
//   OWN_x: x's request is combinationally forwarded to s_*; other master waitreq=1.
//   Accepted transfer = s_read|s_write with s_waitreq=0 at the edge; hold_cnt += 1.
//   Leave OWN_x at an edge with no transfer in flight (x req low, or just accepted) when:
//    x req low -> other req ? OWN_other : IDLE;
//    hold_cnt==HOLD_MAX and other req -> OWN_other; else stay, hold_cnt saturates.
//   Owner change or IDLE entry clears hold_cnt, updates last_owner. No idle bubble on handoff.
//   Never drop a command while s_waitreq=1: held by the same owner until accepted.
//  Reads: each accepted read pushes owner bit into tag FIFO. s_rdvalid pops head and drives
//   that master's rdvalid/rdata same cycle (comb), other rdvalid=0. rdata to non-owner = 0.
//  Back-pressure: tag FIFO full -> s_read forced 0, reading owner sees waitreq=1;
//   writes still pass. Accept and rdvalid in the same cycle: push+pop, count unchanged,
//   pushing allowed when full only if a pop occurs that cycle.
//  s_rdvalid with FIFO empty = protocol error: data discarded, sticky err bit (internal, for
//   assertions only). Pointers wrap mod PEND_MAX.
//  Reset mid-transfer: all state cleared next edge; responses after reset are discarded.
//  Latency: command path 0 cycles combinational; arbitration decision takes effect next edge.
// STRUCTURE
//  Package sdram_arb_pkg: state enum {IDLE,OWN_A,OWN_B}, OWNER_A=0/OWNER_B=1 constants.
//  Sub-module: arb_tag_fifo (1-bit wide, PEND_MAX deep, push/pop/full/empty/count).
//  Top holds FSM, hold counter, command mux, response demux.
// TESTING
//  1 A writes 4 words @0x0000010, B idle, s_waitreq=0 -> gnt=01 4 cycles, s_write=4 pulses.
//  2 A,B request together from reset, B_PRIO=0 -> A owns first; A holds 16 transfers, then
//    B gets gnt=10 on the next edge with no bubble.
//  3 B issues 8 reads, controller returns rdvalid 3 cycles later -> b_rdvalid 8x, a_rdvalid 0,
//    pend_cnt peaks at 3.
//  4 Hold s_rdvalid low, B issues 9 reads -> 9th stalled (b_waitreq=1, pend_cnt=8); first
//    rdvalid releases it same cycle.
//  5 Interleave: A read @0x5, B read @0x6, returns in order -> a gets first, b second word.
//  6 Drop lock for 1 cycle during OWN_B with 2 reads pending -> gnt=00, pend_cnt=0,
//    late rdvalids produce no master rdvalid.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared state encodings and owner-tag values for the SDRAM Avalon arbiter.
package sdram_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWN_A = 2'd1;
    localparam arb_state_t ST_OWN_B = 2'd2;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/arb_tag_fifo.sv
// One-bit owner-tag FIFO recording which master issued each outstanding read.
module arb_tag_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Two-master Avalon-MM arbiter for the SDRAM controller port: round-robin grant,
// bounded burst hold and owner tagging so read data returns to the issuing master.
module sdram_avalon_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned AW       = 25,
    parameter int unsigned DW       = 16,
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned PEND_MAX = 8,
    parameter bit          B_PRIO   = 1'b0
) (
    input  logic                        M100CLK,
    input  logic                        lock,
    input  logic                        a_read,
    input  logic                        a_write,
    input  logic [AW-1:0]               a_addr,
    input  logic [DW/8-1:0]             a_be,
    input  logic [DW-1:0]               a_wdata,
    output logic                        a_waitreq,
    output logic [DW-1:0]               a_rdata,
    output logic                        a_rdvalid,
    input  logic                        b_read,
    input  logic                        b_write,
    input  logic [AW-1:0]               b_addr,
    input  logic [DW/8-1:0]             b_be,
    input  logic [DW-1:0]               b_wdata,
    output logic                        b_waitreq,
    output logic [DW-1:0]               b_rdata,
    output logic                        b_rdvalid,
    output logic                        s_read,
    output logic                        s_write,
    output logic [AW-1:0]               s_addr,
    output logic [DW/8-1:0]             s_be,
    output logic [DW-1:0]               s_wdata,
    input  logic                        s_waitreq,
    input  logic [DW-1:0]               s_rdata,
    input  logic                        s_rdvalid,
    output logic [1:0]                  gnt,
    output logic [$clog2(PEND_MAX):0]   pend_cnt
);

    localparam int unsigned    HCW      = $clog2(HOLD_MAX + 1);
    localparam logic [HCW-1:0] HOLD_LIM = HCW'(HOLD_MAX);

    arb_state_t     state, state_nxt;
    logic [HCW-1:0] hold_cnt, hold_nxt, hold_inc;
    logic           last_owner, last_owner_nxt;
    logic           err;
    logic           a_req, b_req, own_a, own_b;
    logic           fifo_full, fifo_empty, fifo_head;
    logic           push, pop, push_tag, read_block, accepted;

    assign a_req      = a_read | a_write;
    assign b_req      = b_read | b_write;
    assign own_a      = (state == ST_OWN_A);
    assign own_b      = (state == ST_OWN_B);
    assign gnt        = {own_b, own_a};
    assign pop        = s_rdvalid & ~fifo_empty;
    assign read_block = fifo_full & ~pop;

    // Command mux: the owner's request passes straight through; reads held off when tags run out.
    always_comb begin
        s_read  = 1'b0;
        s_write = 1'b0;
        s_addr  = '0;
        s_be    = '0;
        s_wdata = '0;
        if (own_a) begin
            s_read  = a_read & ~read_block;
            s_write = a_write;
            s_addr  = a_addr;
            s_be    = a_be;
            s_wdata = a_wdata;
        end else if (own_b) begin
            s_read  = b_read & ~read_block;
            s_write = b_write;
            s_addr  = b_addr;
            s_be    = b_be;
            s_wdata = b_wdata;
        end
    end

    assign accepted  = (s_read | s_write) & ~s_waitreq;
    assign push      = s_read & ~s_waitreq;
    assign push_tag  = own_b ? OWNER_B : OWNER_A;
    assign a_waitreq = ~own_a | s_waitreq | (a_read & read_block);
    assign b_waitreq = ~own_b | s_waitreq | (b_read & read_block);

    // Response demux steered by the oldest outstanding tag.
    assign a_rdvalid = pop & (fifo_head == OWNER_A);
    assign b_rdvalid = pop & (fifo_head == OWNER_B);
    assign a_rdata   = a_rdvalid ? s_rdata : '0;
    assign b_rdata   = b_rdvalid ? s_rdata : '0;

    assign hold_inc = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + HCW'(1);

    // Grant FSM: ownership only moves at an edge with no command stalled in flight.
    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_cnt;
        last_owner_nxt = last_owner;
        case (state)
            ST_IDLE: begin
                if (a_req && b_req) begin
                    state_nxt = (B_PRIO || last_owner == OWNER_A) ? ST_OWN_B : ST_OWN_A;
                end else if (a_req) begin
                    state_nxt = ST_OWN_A;
                end else if (b_req) begin
                    state_nxt = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (accepted) hold_nxt = hold_inc;
                if (!a_req || (accepted && hold_inc == HOLD_LIM && b_req)) begin
                    state_nxt      = b_req ? ST_OWN_B : ST_IDLE;
                    hold_nxt       = '0;
                    last_owner_nxt = OWNER_A;
                end
            end
            ST_OWN_B: begin
                if (accepted) hold_nxt = hold_inc;
                if (!b_req || (accepted && hold_inc == HOLD_LIM && a_req)) begin
                    state_nxt      = a_req ? ST_OWN_A : ST_IDLE;
                    hold_nxt       = '0;
                    last_owner_nxt = OWNER_B;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge M100CLK) begin
        if (!lock) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            last_owner <= OWNER_B;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            last_owner <= last_owner_nxt;
            if (s_rdvalid && fifo_empty) err <= 1'b1;
        end
    end

    arb_tag_fifo #(
        .DEPTH (PEND_MAX)
    ) u_tag_fifo (
        .clk   (M100CLK),
        .rst_n (lock),
        .push  (push),
        .din   (push_tag),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pend_cnt)
    );

    // Orphan responses are a controller protocol error, flagged for the assertion environment.
    orphan_rsp_seen: cover property (@(posedge M100CLK) disable iff (!lock) err);
    one_cmd_at_a_time: assert property (@(posedge M100CLK) disable iff (!lock) !(s_read && s_write));

endmodule
